overlay_fb_writer: RTL and testbench

//  Consumer end of the line_gen pixel stream: accepts projected (x,y,color) points and writes them into a

---
 rtl/overlay_pkg.sv | 19 +
 rtl/fb_coord_clip.sv | 23 ++
 rtl/overlay_fb_writer.sv | 131 +++++++++++++
 tb/tb_overlay_fb_writer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/overlay_pkg.sv
// Overlay framebuffer writer: shared types and default geometry.
// Holds FB size constants, the color index type and the writer FSM states.
package overlay_pkg;

  localparam int H_PIX_DEF = 1280;
  localparam int V_PIX_DEF = 720;
  localparam int SHIFT_DEF = 2;
  localparam int FB_W      = H_PIX_DEF >> SHIFT_DEF;
  localparam int FB_H      = V_PIX_DEF >> SHIFT_DEF;
  localparam int FB_DEPTH  = FB_W * FB_H;

  typedef logic [3:0] color_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } fb_state_t;

endpackage

// File: rtl/fb_coord_clip.sv
// Screen-space clip and downsample for one projected pixel (pipeline S1).
// Ports: x/y signed pixel coords in; in_range flag, xs/ys fb cell coords out.
module fb_coord_clip #(
  parameter int H_PIX  = 1280,
  parameter int V_PIX  = 720,
  parameter int SHIFT  = 2,
  parameter int ADDR_W = 16
) (
  input  logic signed [31:0]  x,
  input  logic signed [31:0]  y,
  output logic                in_range,
  output logic [ADDR_W-1:0]   xs,
  output logic [ADDR_W-1:0]   ys
);

  assign in_range = (x >= 0) && (x < H_PIX) &&
                    (y >= 0) && (y < V_PIX);

  // Only meaningful when in_range; truncation is harmless there.
  assign xs = ADDR_W'(x >>> SHIFT);
  assign ys = ADDR_W'(y >>> SHIFT);

endmodule

// File: rtl/overlay_fb_writer.sv
// Writes line_gen pixels into a downsampled overlay framebuffer BRAM.
// Ports: clk_in/rst_in; x_in,y_in,color_in,data_valid_in -> ready_out;
// frame_start_in -> clear_busy_out; wr_en/addr/data_out BRAM port;
// drop_count_out counts clipped pixels since the last frame start.
module overlay_fb_writer
  import overlay_pkg::*;
#(
  parameter int H_PIX   = 1280,
  parameter int V_PIX   = 720,
  parameter int SHIFT   = 2,
  parameter int COLOR_W = 4,
  parameter int ADDR_W  = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic signed [31:0]  x_in,
  input  logic signed [31:0]  y_in,
  input  logic [COLOR_W-1:0]  color_in,
  input  logic                data_valid_in,
  output logic                ready_out,
  input  logic                frame_start_in,
  output logic                clear_busy_out,
  output logic                wr_en_out,
  output logic [ADDR_W-1:0]   wr_addr_out,
  output logic [COLOR_W-1:0]  wr_data_out,
  output logic [15:0]         drop_count_out
);

  localparam int CW = H_PIX >> SHIFT;
  localparam int CH = V_PIX >> SHIFT;
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(CW * CH - 1);
  localparam logic [ADDR_W-1:0] CW_A   = ADDR_W'(CW);

  fb_state_t            state;
  logic [ADDR_W-1:0]    clr_addr;

  logic                 accept;
  logic                 in_range;
  logic [ADDR_W-1:0]    xs;
  logic [ADDR_W-1:0]    ys;

  logic                 s1_valid;
  logic [ADDR_W-1:0]    s1_xs;
  logic [ADDR_W-1:0]    s1_ys;
  logic [COLOR_W-1:0]   s1_color;

  logic [ADDR_W-1:0]    s2_addr;
  logic                 s2_dup;
  logic                 s2_wr;

  logic                 last_valid;
  logic [ADDR_W-1:0]    last_addr;
  logic [COLOR_W-1:0]   last_color;

  assign ready_out      = (state == RUN);
  assign clear_busy_out = (state == CLEAR);
  assign accept         = data_valid_in & ready_out;

  fb_coord_clip #(
    .H_PIX  (H_PIX),
    .V_PIX  (V_PIX),
    .SHIFT  (SHIFT),
    .ADDR_W (ADDR_W)
  ) u_clip (
    .x        (x_in),
    .y        (y_in),
    .in_range (in_range),
    .xs       (xs),
    .ys       (ys)
  );

  assign s2_addr = s1_ys * CW_A + s1_xs;
  // Re-writing the same color to the same cell is wasted BRAM bandwidth.
  assign s2_dup  = last_valid &&
                   (last_addr == s2_addr) &&
                   (last_color == s1_color);
  assign s2_wr   = s1_valid & ~s2_dup;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= CLEAR;
      clr_addr       <= '0;
      s1_valid       <= 1'b0;
      s1_xs          <= '0;
      s1_ys          <= '0;
      s1_color       <= '0;
      wr_en_out      <= 1'b0;
      wr_addr_out    <= '0;
      wr_data_out    <= '0;
      drop_count_out <= '0;
      last_valid     <= 1'b0;
      last_addr      <= '0;
      last_color     <= '0;
    end else if (frame_start_in) begin
      // Both stages and any same-cycle accept are discarded.
      state          <= CLEAR;
      clr_addr       <= '0;
      s1_valid       <= 1'b0;
      wr_en_out      <= 1'b0;
      drop_count_out <= '0;
      last_valid     <= 1'b0;
    end else if (state == CLEAR) begin
      s1_valid    <= 1'b0;
      wr_en_out   <= 1'b1;
      wr_addr_out <= clr_addr;
      wr_data_out <= '0;
      if (clr_addr == LAST_A) begin
        state    <= RUN;
        clr_addr <= '0;
      end else begin
        clr_addr <= clr_addr + ADDR_W'(1);
      end
    end else begin
      s1_valid <= accept & in_range & (|color_in);
      s1_xs    <= xs;
      s1_ys    <= ys;
      s1_color <= color_in;
      if (accept && !in_range && drop_count_out != 16'hFFFF)
        drop_count_out <= drop_count_out + 16'd1;
      wr_en_out <= s2_wr;
      if (s2_wr) begin
        wr_addr_out <= s2_addr;
        wr_data_out <= s1_color;
        last_valid  <= 1'b1;
        last_addr   <= s2_addr;
        last_color  <= s1_color;
      end
    end
  end

endmodule

// File: tb/tb_overlay_fb_writer.sv
// Directed self-checking bench for overlay_fb_writer.
// Drives and samples on the falling edge; DUT acts on the rising edge.
module tb_overlay_fb_writer;

  localparam int DEPTH = 320 * 180;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [31:0] x = '0;
  logic signed [31:0] y = '0;
  logic [3:0]         color = '0;
  logic               valid = 1'b0;
  logic               ready;
  logic               fs = 1'b0;
  logic               busy;
  logic               wr_en;
  logic [15:0]        wr_addr;
  logic [3:0]         wr_data;
  logic [15:0]        drop;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  overlay_fb_writer dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .x_in           (x),
    .y_in           (y),
    .color_in       (color),
    .data_valid_in  (valid),
    .ready_out      (ready),
    .frame_start_in (fs),
    .clear_busy_out (busy),
    .wr_en_out      (wr_en),
    .wr_addr_out    (wr_addr),
    .wr_data_out    (wr_data),
    .drop_count_out (drop)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pix(input int px, input int py, input int pc);
    x     = px;
    y     = py;
    color = 4'(pc);
    valid = 1'b1;
  endtask

  task automatic idle();
    valid = 1'b0;
  endtask

  task automatic exp_wr(input string tag, input int a, input int d);
    check({tag, ".en"}, 32'(wr_en), 32'd1);
    check({tag, ".addr"}, 32'(wr_addr), 32'(a));
    check({tag, ".data"}, 32'(wr_data), 32'(d));
  endtask

  task automatic exp_nowr(input string tag);
    check({tag, ".en"}, 32'(wr_en), 32'd0);
  endtask

  initial begin
    logic [15:0] ia;
    int f0;

    // Reset values
    cyc();
    check("rst.busy", 32'(busy), 32'd1);
    check("rst.ready", 32'(ready), 32'd0);
    check("rst.en", 32'(wr_en), 32'd0);
    check("rst.addr", 32'(wr_addr), 32'd0);
    check("rst.data", 32'(wr_data), 32'd0);
    check("rst.drop", 32'(drop), 32'd0);

    // 1: full clear sweep after reset release
    @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    check("clr.pre_en", 32'(wr_en), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc();
      ia = 16'(i);
      f0 = n_chk - n_pass;
      check("clr.sweep",
            {10'd0, busy && (i < DEPTH - 1), wr_en, wr_addr, wr_data},
            {10'd0, (i < DEPTH - 1) ? 1'b1 : 1'b0, 1'b1, ia, 4'd0});
      if (n_chk - n_pass != f0) break;
    end
    check("clr.ready", 32'(ready), 32'd1);
    check("clr.busy_end", 32'(busy), 32'd0);

    // 2: single pixel, 2-cycle latency
    pix(300, 300, 1);
    cyc();
    idle();
    exp_nowr("t2.lat1");
    cyc();
    exp_wr("t2", 24075, 1);
    cyc();
    exp_nowr("t2.after");

    // 3: two clipped pixels
    pix(-5, 10, 2);
    cyc();
    pix(100, 720, 2);
    cyc();
    idle();
    exp_nowr("t3.c1");
    cyc();
    exp_nowr("t3.c2");
    cyc();
    exp_nowr("t3.c3");
    check("t3.drop", 32'(drop), 32'd2);

    // 4: transparent pixel
    pix(400, 400, 0);
    cyc();
    idle();
    cyc();
    exp_nowr("t4.c1");
    cyc();
    exp_nowr("t4.c2");
    check("t4.drop", 32'(drop), 32'd2);

    // Corner cells: last in-range pixel writes, first past edge drops
    pix(1279, 719, 7);
    cyc();
    pix(1280, 0, 7);
    cyc();
    idle();
    exp_wr("edge.in", 57599, 7);
    cyc();
    exp_nowr("edge.out");
    check("edge.drop", 32'(drop), 32'd3);

    // Move the tracker off 24075 before the duplicate test
    pix(0, 0, 5);
    cyc();
    idle();
    cyc();
    exp_wr("t5.pre", 0, 5);

    // 5: back-to-back with a duplicate in the middle
    pix(300, 300, 1);
    cyc();
    pix(301, 301, 1);
    cyc();
    pix(302, 300, 3);
    exp_wr("t5.p0", 24075, 1);
    cyc();
    idle();
    exp_nowr("t5.p1dup");
    cyc();
    exp_wr("t5.p2", 24075, 3);
    cyc();
    exp_nowr("t5.idle");

    // 6: frame start discards an in-flight pixel
    pix(500, 500, 2);
    cyc();
    idle();
    fs = 1'b1;
    cyc();
    fs = 1'b0;
    exp_nowr("t6.flush");
    check("t6.busy", 32'(busy), 32'd1);
    check("t6.ready", 32'(ready), 32'd0);
    check("t6.drop", 32'(drop), 32'd0);
    cyc();
    exp_wr("t6.clr0", 0, 0);
    cyc();
    exp_wr("t6.clr1", 1, 0);
    cyc();
    exp_wr("t6.clr2", 2, 0);

    // Async reset mid-sweep
    rst = 1'b1;
    #1;
    check("t6.rst.en", 32'(wr_en), 32'd0);
    check("t6.rst.addr", 32'(wr_addr), 32'd0);
    check("t6.rst.busy", 32'(busy), 32'd1);
    check("t6.rst.ready", 32'(ready), 32'd0);
    cyc();
    cyc();
    check("t6.rst.hold", 32'(wr_en), 32'd0);
    rst = 1'b0;
    cyc();
    exp_wr("t6.re0", 0, 0);
    cyc();
    exp_wr("t6.re1", 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
